// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: default data width and register-address type.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned NUM_REGS_DEFAULT = 32;

  typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] reg_addr_t;

endpackage : rv_pkg

// File: rtl/rv_gpr_sb_if.sv
// Port bundle of the GPR file with scoreboard: write ports, read ports and claim handshake.
interface rv_gpr_sb_if #(
  parameter int XLEN     = rv_pkg::XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0]           wr_en_i;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i;
  logic [NUM_WR-1:0]           wr_rel_i;

  logic [NUM_RD-1:0][AW-1:0]   rd_addr_i;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]           rd_busy_o;

  logic                        claim_en_i;
  logic [AW-1:0]               claim_addr_i;
  logic                        claim_ok_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_rel_i,
    output rd_addr_i, claim_en_i, claim_addr_i,
    input  rd_data_o, rd_busy_o, claim_ok_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_rel_i,
    input  rd_addr_i, claim_en_i, claim_addr_i,
    output rd_data_o, rd_busy_o, claim_ok_o
  );

endinterface : rv_gpr_sb_if

// File: rtl/rv_gpr_wr_arb.sv
// Per-register write resolution: highest-index write port to an address wins enable, data and release.
module rv_gpr_wr_arb
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic [NUM_WR-1:0]             wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data_i,
  input  logic [NUM_WR-1:0]             wr_rel_i,
  output logic [NUM_REGS-1:0]           reg_we_o,
  output logic [NUM_REGS-1:0][XLEN-1:0] reg_wdata_o,
  output logic [NUM_REGS-1:0]           reg_rel_o
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
    reg_we_o    = '0;
    reg_wdata_o = '0;
    reg_rel_o   = '0;
    // NOTE: blocking assignments in combinational logic let later (higher) ports override earlier ones.
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en_i[p]) begin
        reg_we_o[wr_addr_i[p]]    = 1'b1;
        reg_wdata_o[wr_addr_i[p]] = wr_data_i[p];
        reg_rel_o[wr_addr_i[p]]   = wr_rel_i[p];
      end
    end
    // x0 is hardwired: never written, never released
    reg_we_o[0]    = 1'b0;
    reg_wdata_o[0] = '0;
    reg_rel_o[0]   = 1'b0;
  end

endmodule : rv_gpr_wr_arb

// File: rtl/rv_gpr_sb.sv
// Multi-port GPR file with busy-bit scoreboard for long-latency producers.
// Optional same-cycle write-to-read forwarding with `define RV_GPR_BYPASS_EN.
module rv_gpr_sb
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic        clk_i,
  input  logic        arst_i,
  rv_gpr_sb_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]                regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]            busy_q;
  logic [NUM_REGS-1:0]            reg_we;
  logic [NUM_REGS-1:0][XLEN-1:0]  reg_wdata;
  logic [NUM_REGS-1:0]            reg_rel;
  logic                           claim_ok;
  logic                           claim_take;

  rv_gpr_wr_arb #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_wr_arb (
    .wr_en_i     (bus.wr_en_i),
    .wr_addr_i   (bus.wr_addr_i),
    .wr_data_i   (bus.wr_data_i),
    .wr_rel_i    (bus.wr_rel_i),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata),
    .reg_rel_o   (reg_rel)
  );

  // A busy target may still be claimed when its producer retires in this same cycle.
  always_comb begin
    claim_ok = 1'b0;
    if (!arst_i && bus.claim_en_i) begin
      claim_ok = (bus.claim_addr_i == '0) || !busy_q[bus.claim_addr_i]
                 || reg_rel[bus.claim_addr_i];
    end
    claim_take = claim_ok && (bus.claim_addr_i != '0);
  end

  assign bus.claim_ok_o = claim_ok;

  // NOTE: the register array is reset because software relies on zeroed GPRs; this keeps it in flops.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reg_we[r]) begin
          regs_q[r] <= reg_wdata[r];
        end
        // claim has priority over release so an overlapping claim leaves the register busy
        if (claim_take && (bus.claim_addr_i == AW'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (reg_rel[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      bus.rd_data_o[r] = regs_q[bus.rd_addr_i[r]];
      bus.rd_busy_o[r] = busy_q[bus.rd_addr_i[r]];
`ifdef RV_GPR_BYPASS_EN
      if (reg_we[bus.rd_addr_i[r]]) begin
        bus.rd_data_o[r] = reg_wdata[bus.rd_addr_i[r]];
      end
      if (reg_rel[bus.rd_addr_i[r]]) begin
        bus.rd_busy_o[r] = 1'b0;
      end
`endif
      if (arst_i) begin
        bus.rd_data_o[r] = '0;
        bus.rd_busy_o[r] = 1'b0;
      end
    end
  end

endmodule : rv_gpr_sb

// File: doc/rv_gpr_sb.md
RV_GPR_SB -- requirements
Module: rv_gpr_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, >=2); AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, meaning number of write ports.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 arst_i  in  1  asynchronous, active-high reset.
REQ-007 wr_en_i  in  [NUM_WR]  per-port write enable.
REQ-008 wr_addr_i  in  [NUM_WR][AW]  per-port write address.
REQ-009 wr_data_i  in  [NUM_WR][XLEN]  per-port write data.
REQ-010 wr_rel_i  in  [NUM_WR]  per-port release: the write also clears the busy bit of wr_addr_i.
REQ-011 rd_addr_i  in  [NUM_RD][AW]  per-port read address.
REQ-012 rd_data_o  out  [NUM_RD][XLEN]  combinational read data.
REQ-013 rd_busy_o  out  [NUM_RD]  busy bit of rd_addr_i (pending long-latency producer).
REQ-014 claim_en_i  in  1  request to mark claim_addr_i busy (MUL/DIV issue).
REQ-015 claim_addr_i  in  [AW]  register to claim.
REQ-016 claim_ok_o  out  1  combinational; claim accepted this cycle.

Function
REQ-017 Register 0 SHALL read as 0, ignore writes, never be busy; claims to register 0 SHALL report claim_ok_o=1 with no state change.
REQ-018 A write with wr_en_i[p]=1 SHALL update the register on the next rising edge (1-cycle write latency).
REQ-019 Same-address writes in one cycle: highest port index SHALL win; lower ports discarded.
REQ-020 Reads SHALL be combinational from current state (0-cycle latency), independent per port.
REQ-021 Busy bits: claim sets, release (wr_en_i & wr_rel_i) clears, on the rising edge.
REQ-022 claim_ok_o SHALL be 1 iff claim_en_i=1 and target not busy, or target is being released this cycle; else 0 and no state change (WAW stall).
REQ-023 Claim and release of the same register in one cycle: register SHALL end busy (claim wins).
REQ-024 Release of a non-busy register SHALL still write data; busy stays 0.
REQ-025 Write without release to a busy register SHALL write data and leave busy set.
REQ-026 rd_busy_o SHALL reflect registered busy state only (no release forwarding).

Reset
REQ-027 arst_i=1 SHALL asynchronously clear all registers and busy bits; rd_data_o=0, rd_busy_o=0 while asserted.
REQ-028 A claim or write coinciding with arst_i SHALL be discarded.

Configuration
REQ-029 With RV_GPR_BYPASS_EN defined, rd_data_o[r] SHALL forward wr_data_i of the winning same-address write in the same cycle, and rd_busy_o[r] SHALL be 0 if that write releases; register 0 never bypassed.
REQ-030 Without RV_GPR_BYPASS_EN, reads SHALL return pre-write state; new value visible the following cycle.

Structure
REQ-031 Shared package rv_pkg SHALL hold XLEN default and register-address typedef; block parameters stay local.
REQ-032 One sub-module rv_gpr_wr_arb SHALL resolve per-register write enable/data and release by port priority.

Verification
REQ-033 Reset: arst_i pulse mid-traffic -> all rd_data_o=0, rd_busy_o=0 immediately.
REQ-034 Port0 x5<=0x11, port1 x5<=0x22 same cycle -> next cycle x5 reads 0x22.
REQ-035 Claim x7; claim x7 again next cycle -> claim_ok_o=0, busy stays 1; port1 writes 0xABCD with release -> busy 0, x7=0xABCD.
REQ-036 Release x7 and claim x7 same cycle -> claim_ok_o=1, x7 busy afterwards.
REQ-037 Write x0<=0xFFFF_FFFF, claim x0 -> reads 0, rd_busy_o=0.
REQ-038 Read x3 while writing 0x55 to x3: bypass build -> 0x55 same cycle; non-bypass -> old value, 0x55 next cycle.
